uart_rx_ctrl: RTL

//   UART receive controller for the host serial link, 8 data bits, LSB first, optional parity, 1 stop bit.

---
 rtl/uart_rx_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronizes rs232_rx, samples it on the baud generator's mid-bit
// strobe and hands complete bytes to the consumer through a valid/ack handshake with error flags.
module uart_rx_ctrl #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rs232_rx,
  input  logic                 clk_bps,
  output logic                 bps_start,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic [2:0]           fsm_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BRK    = 3'd5;

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic       ODD      = (PARITY_ODD != 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   primed_q;
  logic                   rs_s;
  logic                   rs_d;
  logic                   fall;
  logic [2:0]             state;
  logic [3:0]             bitcnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   perr;

  assign rs_s = sync_q[SYNC_STAGES-1];

  // A fall is only trusted once both rs_s and rs_d hold real line samples, so a line that
  // is already low when reset releases is not mistaken for a start bit.
  assign fall      = primed_q[SYNC_STAGES] & rs_d & ~rs_s;
  assign rx_busy   = (state != S_IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '1;
      primed_q <= '0;
      rs_d     <= 1'b1;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], rs232_rx};
      primed_q <= {primed_q[SYNC_STAGES-1:0], 1'b1};
      rs_d     <= rs_s;
    end
  end

  // Handshake: rx_valid is a level held until rx_ack is high on a clock edge; rx_ack also
  // clears overrun. A byte completing on the same edge as rx_ack keeps rx_valid set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      bps_start  <= 1'b0;
      bitcnt     <= 4'd0;
      shreg      <= '0;
      perr       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      if (rx_ack) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (fall) begin
            state     <= S_START;
            bps_start <= 1'b1;
            perr      <= 1'b0;
          end
        end
        S_START: begin
          if (clk_bps) begin
            if (rs_s) begin
              state     <= S_IDLE;
              bps_start <= 1'b0;
            end else begin
              state  <= S_DATA;
              bitcnt <= 4'd0;
            end
          end
        end
        S_DATA: begin
          if (clk_bps) begin
            // Shifting in from the top leaves the first (LSB) bit at position 0.
            shreg  <= {rs_s, shreg[DATA_BITS-1:1]};
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt == LAST_BIT) begin
              state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (clk_bps) begin
            perr  <= (^shreg) ^ rs_s ^ ODD;
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (clk_bps) begin
            bps_start <= 1'b0;
            if (rs_s) begin
              rx_data    <= shreg;
              rx_valid   <= 1'b1;
              parity_err <= perr;
              if (rx_valid && !rx_ack) begin
                overrun <= 1'b1;
              end
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BRK;
            end
          end
        end
        S_BRK: begin
          if (rs_s) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          bps_start <= 1'b0;
        end
      endcase
    end
  end

endmodule
